// File: rtl/sorter_pkg.sv
// Shared types and default sizing for the in-place memory bubble sorter.
package sorter_pkg;

    localparam int SORT_DEPTH  = 32;
    localparam int SORT_ADDR_W = 5;
    localparam int SORT_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CMP,
        S_WR_A,
        S_WR_B,
        S_PASS,
        S_DONE
    } sorter_state_t;

endpackage

// File: rtl/mem_bubble_sorter.sv
// In-place ascending bubble sort of an external asynchronous-read memory.
// Optional SORTER_EARLY_EXIT_EN: stop after the first pass with no swaps.
module mem_bubble_sorter
    import sorter_pkg::*;
#(
    parameter int DEPTH  = SORT_DEPTH,
    parameter int ADDR_W = SORT_ADDR_W,
    parameter int DATA_W = SORT_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_adr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [2*ADDR_W-1:0] swap_cnt
);

    localparam logic [ADDR_W-1:0]   LAST_P  = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0]   ONE_A   = ADDR_W'(1);
    localparam logic [2*ADDR_W-1:0] ONE_CNT = (2*ADDR_W)'(1);

    sorter_state_t     state, stateNxt;
    logic [ADDR_W-1:0] p, i;
    logic [DATA_W-1:0] a, b;
    logic              lastI;
    logic              passFinal;

`ifdef SORTER_EARLY_EXIT_EN
    logic swapped;
    assign passFinal = (p == LAST_P) || !swapped;
`else
    assign passFinal = (p == LAST_P);
`endif

    // Each pass shrinks by one: the largest remaining word is already in place.
    assign lastI = (i == (LAST_P - p));

    always_comb begin
        stateNxt  = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (start) stateNxt = S_RD_A;
            end
            S_RD_A: begin
                mem_rd   = 1'b1;
                mem_adr  = i;
                stateNxt = S_RD_B;
            end
            S_RD_B: begin
                mem_rd   = 1'b1;
                mem_adr  = i + ONE_A;
                stateNxt = S_CMP;
            end
            S_CMP: begin
                if (a > b)      stateNxt = S_WR_A;
                else if (lastI) stateNxt = S_PASS;
                else            stateNxt = S_RD_A;
            end
            S_WR_A: begin
                mem_wr    = 1'b1;
                mem_adr   = i;
                mem_wdata = b;
                stateNxt  = S_WR_B;
            end
            S_WR_B: begin
                mem_wr    = 1'b1;
                mem_adr   = i + ONE_A;
                mem_wdata = a;
                stateNxt  = lastI ? S_PASS : S_RD_A;
            end
            S_PASS: begin
                stateNxt = passFinal ? S_DONE : S_RD_A;
            end
            S_DONE: begin
                stateNxt = S_IDLE;
            end
            default: stateNxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            p        <= '0;
            i        <= '0;
            a        <= '0;
            b        <= '0;
            swap_cnt <= '0;
`ifdef SORTER_EARLY_EXIT_EN
            swapped  <= 1'b0;
`endif
        end else begin
            state <= stateNxt;
            // Flags track the next state so they line up with it cycle for cycle.
            busy  <= (stateNxt != S_IDLE) && (stateNxt != S_DONE);
            done  <= (stateNxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p        <= '0;
                        i        <= '0;
                        swap_cnt <= '0;
`ifdef SORTER_EARLY_EXIT_EN
                        swapped  <= 1'b0;
`endif
                    end
                end
                S_RD_A: a <= mem_rdata;
                S_RD_B: b <= mem_rdata;
                S_CMP: begin
                    if (!(a > b) && !lastI) i <= i + ONE_A;
                end
                S_WR_B: begin
                    swap_cnt <= swap_cnt + ONE_CNT;
`ifdef SORTER_EARLY_EXIT_EN
                    swapped  <= 1'b1;
`endif
                    if (!lastI) i <= i + ONE_A;
                end
                S_PASS: begin
                    if (!passFinal) begin
                        p       <= p + ONE_A;
                        i       <= '0;
`ifdef SORTER_EARLY_EXIT_EN
                        swapped <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bubble_sorter.sv
// Scoreboard bench for mem_bubble_sorter with a simple async-read memory model.
module tb_mem_bubble_sorter;
    import sorter_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 8;

    typedef logic [DEPTH-1:0][DW-1:0] img_t;

    typedef struct packed {
        int   swaps;
        int   busyCyc;   // -1: not checked
        logic noWr;
        img_t mem;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, memRd, memWr;
    logic [AW-1:0] memAdr;
    logic [DW-1:0] memWdata, memRdata;
    logic [2*AW-1:0] swapCnt;

    logic [DW-1:0] mem [DEPTH];

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    mem_bubble_sorter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_rd   (memRd),
        .mem_wr   (memWr),
        .mem_adr  (memAdr),
        .mem_wdata(memWdata),
        .mem_rdata(memRdata),
        .swap_cnt (swapCnt)
    );

    always @(posedge clk) if (memWr) mem[memAdr] <= memWdata;
    assign memRdata = mem[memAdr];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: accumulates per-run activity and scores it when done pulses.
    int   busyCyc = 0;
    int   wrCnt = 0;
    logic prevDone = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busyCyc  = 0;
            wrCnt    = 0;
            prevDone = 1'b0;
        end else begin
            if (busy) busyCyc++;
            if (memWr) begin
                wrCnt++;
                check("rd_wr_exclusive", memRd, 0);
            end
            if (prevDone) check("done_single_cycle", done, 0);
            if (done) begin
                check("done_expected", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("swap_cnt", swapCnt, e.swaps);
                    if (e.busyCyc >= 0) check("busy_cycles", busyCyc, e.busyCyc);
                    if (e.noWr) check("no_writes", wrCnt, 0);
                    for (int k = 0; k < DEPTH; k++)
                        check($sformatf("mem[%0d]", k), mem[k], e.mem[k]);
                end
                busyCyc = 0;
                wrCnt   = 0;
            end
            prevDone = done;
        end
    end

    task automatic loadMem(input img_t img);
        for (int k = 0; k < DEPTH; k++) mem[k] = img[k];
    endtask

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pushExp(input int swaps, input int busyC, input logic noWr, input img_t m);
        exp_t e;
        e.swaps   = swaps;
        e.busyCyc = busyC;
        e.noWr    = noWr;
        e.mem     = m;
        expQ.push_back(e);
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, done, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mem_rd"}, memRd, 0);
        check({tag, "_mem_wr"}, memWr, 0);
        check({tag, "_mem_adr"}, memAdr, 0);
        check({tag, "_mem_wdata"}, memWdata, 0);
        check({tag, "_swap_cnt"}, swapCnt, 0);
    endtask

    img_t rev, asc, flat, mixIn, mixOut, snap, srt;
    int   inv, cnt, n;

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            rev[k]  = DW'(31 - k);
            asc[k]  = DW'(k);
            flat[k] = 8'h55;
            mixIn[k]  = 8'h10;
            mixOut[k] = 8'h10;
        end
        mixIn[0]  = 8'hFF;
        mixIn[1]  = 8'h00;
        mixOut[0] = 8'h00;
        mixOut[31] = 8'hFF;

        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        rst_n = 1'b1;

        // Reverse input: worst case, every compare swaps.
        loadMem(rev);
        pushExp(496, 2511, 1'b0, asc);
        pulseStart();
        waitDone("done_reverse");

        // Already sorted.
        loadMem(asc);
`ifdef SORTER_EARLY_EXIT_EN
        pushExp(0, 94, 1'b1, asc);
`else
        pushExp(0, 1519, 1'b1, asc);
`endif
        pulseStart();
        waitDone("done_sorted");

        // All equal words: never swapped.
        loadMem(flat);
`ifdef SORTER_EARLY_EXIT_EN
        pushExp(0, 94, 1'b1, flat);
`else
        pushExp(0, 1519, 1'b1, flat);
`endif
        pulseStart();
        waitDone("done_flat");

        // Unsigned ordering: 0xFF bubbles to the top in one pass.
        loadMem(mixIn);
`ifdef SORTER_EARLY_EXIT_EN
        pushExp(31, 247, 1'b0, mixOut);
`else
        pushExp(31, 1581, 1'b0, mixOut);
`endif
        pulseStart();
        waitDone("done_unsigned");

        // Extra starts while busy are ignored.
        loadMem(rev);
        pushExp(496, 2511, 1'b0, asc);
        pulseStart();
        repeat (10) @(negedge clk);
        pulseStart();
        repeat (1000) @(negedge clk);
        pulseStart();
        waitDone("done_double_start");
        check("queue_drained", expQ.size(), 0);

        // Abort with reset during the first WR_A of pass 3.
        loadMem(rev);
        pulseStart();
        cnt = 0;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (memRd && memAdr == 0) cnt++;
            if (cnt == 4 && memWr) break;
        end
        check("reached_pass3_wr_a", memWr, 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkIdleOutputs("abort");
        rst_n = 1'b1;

        // Re-sort whatever the abort left behind.
        for (int k = 0; k < DEPTH; k++) snap[k] = mem[k];
        inv = 0;
        for (int x = 0; x < DEPTH; x++)
            for (int y = x + 1; y < DEPTH; y++)
                if (snap[x] > snap[y]) inv++;
        srt = snap;
        for (int x = 0; x < DEPTH; x++)
            for (int y = x + 1; y < DEPTH; y++)
                if (srt[y] < srt[x]) begin
                    logic [DW-1:0] t;
                    t = srt[x];
                    srt[x] = srt[y];
                    srt[y] = t;
                end
`ifdef SORTER_EARLY_EXIT_EN
        pushExp(inv, -1, 1'b0, srt);
`else
        pushExp(inv, 1519 + 2 * inv, 1'b0, srt);
`endif
        pulseStart();
        waitDone("done_after_abort");
        check("queue_empty_end", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
